// File: rtl/div5_serial_tx_if.sv
// div5_serial_tx_if: word handshake in, serial frame and detector reference out.
interface div5_serial_tx_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             exp_y;
    logic             done;
    logic [2:0]       final_rem;
    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last, exp_y, done, final_rem
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, ser_first, ser_last, exp_y, done, final_rem
    );
endinterface

// File: rtl/div5_serial_tx.sv
// div5_serial_tx: MSB-first serializer that tracks the running prefix mod 5
// and drives the value a divisible-by-5 Moore detector must show.
module div5_serial_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input logic             clk,
    input logic             reset,
    div5_serial_tx_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_GAP} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [2:0]       res, res_nx, rem;
    logic [3:0]       gcnt;
    logic             ey, sh;
    // (2*r + b) mod 5 as a lookup; residue never exceeds 4
    always_comb begin
        case ({res, shreg[WIDTH-1]})
            4'd1:    res_nx = 3'd1;
            4'd2:    res_nx = 3'd2;
            4'd3:    res_nx = 3'd3;
            4'd4:    res_nx = 3'd4;
            4'd6:    res_nx = 3'd1;
            4'd7:    res_nx = 3'd2;
            4'd8:    res_nx = 3'd3;
            4'd9:    res_nx = 3'd4;
            default: res_nx = 3'd0;
        endcase
    end
    always_comb begin
        state_nx = state;
        sh = state == S_SHIFT;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nx = S_SHIFT;
            S_SHIFT: if (cnt == '0) state_nx = S_DONE;
            S_DONE:  state_nx = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (gcnt == '0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        bus.in_ready  = state == S_IDLE;
        bus.ser_valid = sh;
        bus.ser_out   = sh & shreg[WIDTH-1];
        bus.ser_first = sh && cnt == CMAX;
        bus.ser_last  = sh && cnt == '0;
        bus.done      = state == S_DONE;
        bus.exp_y     = ey;
        bus.final_rem = rem;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
            res   <= '0;
            rem   <= '0;
            gcnt  <= '0;
            ey    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    shreg <= bus.in_data;
                    cnt   <= CMAX;
                    res   <= '0;
                    ey    <= 1'b0;
                end
                S_SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                    res   <= res_nx;
                    ey    <= res_nx == 3'd0;
                    if (cnt == '0) rem <= res_nx;
                end
                S_DONE:  gcnt <= 4'(GAP - 1);
                S_GAP:   gcnt <= gcnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div5_serial_tx.sv
// tb_div5_serial_tx: directed frames on an 8-bit/GAP=1 and a 7-bit/GAP=0 transmitter,
// checked by a queue scoreboard and a behavioural divisible-by-5 detector.
module tb_div5_serial_tx;
    typedef struct packed {logic b; logic f; logic l; logic y;} exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, errors = 0, cyc = 0;
    exp_t qa[$], qb[$];
    int ra[$], rb[$];
    bit pv[2], py[2];
    int dcnt[2], acc[2], t_acc[2], t_prev[2];
    logic [2:0] da, db;
    logic sa, sb, ya, yb;
    div5_serial_tx_if #(.WIDTH(8)) a();
    div5_serial_tx_if #(.WIDTH(7)) b();
    div5_serial_tx #(.WIDTH(8), .GAP(1)) dut_a (.clk(clk), .reset(reset), .bus(a));
    div5_serial_tx #(.WIDTH(7), .GAP(0)) dut_b (.clk(clk), .reset(reset), .bus(b));
    always #5 clk = ~clk;
    // detector starts in a "no bits yet" state with y=0 and is cleared on every accept
    assign ya = sa && da == 3'd0;
    assign yb = sb && db == 3'd0;
    always @(posedge clk or posedge reset)
        if (reset) begin da <= 0; sa <= 0; end
        else if (a.in_valid && a.in_ready) begin da <= 0; sa <= 0; end
        else if (a.ser_valid) begin da <= 3'((2 * int'(da) + int'(a.ser_out)) % 5); sa <= 1; end
    always @(posedge clk or posedge reset)
        if (reset) begin db <= 0; sb <= 0; end
        else if (b.in_valid && b.in_ready) begin db <= 0; sb <= 0; end
        else if (b.ser_valid) begin db <= 3'((2 * int'(db) + int'(b.ser_out)) % 5); sb <= 1; end
    always @(posedge clk) begin
        cyc++;
        if (!reset && a.in_valid && a.in_ready) begin acc[0]++; t_prev[0] = t_acc[0]; t_acc[0] = cyc; end
        if (!reset && b.in_valid && b.in_ready) begin acc[1]++; t_prev[1] = t_acc[1]; t_acc[1] = cyc; end
    end
    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", n, got, want, cyc);
        end
    endtask
    task automatic mon(input bit s);
        exp_t e;
        int r;
        logic sv, so, sf, sl, ey, dn, y;
        logic [2:0] fr;
        sv = s ? b.ser_valid : a.ser_valid;
        so = s ? b.ser_out : a.ser_out;
        sf = s ? b.ser_first : a.ser_first;
        sl = s ? b.ser_last : a.ser_last;
        ey = s ? b.exp_y : a.exp_y;
        dn = s ? b.done : a.done;
        fr = s ? b.final_rem : a.final_rem;
        y  = s ? yb : ya;
        if (pv[s]) begin
            chk(s ? "exp_y_b" : "exp_y_a", int'(ey), int'(py[s]));
            chk(s ? "det_y_b" : "det_y_a", int'(y), int'(ey));
            pv[s] = 0;
        end
        if (sv) begin
            chk(s ? "det_y_bit_b" : "det_y_bit_a", int'(y), int'(ey));
            if ((s ? qb.size() : qa.size()) == 0) chk(s ? "extra_bit_b" : "extra_bit_a", 1, 0);
            else begin
                if (s) e = qb.pop_front(); else e = qa.pop_front();
                chk(s ? "ser_out_b" : "ser_out_a", int'(so), int'(e.b));
                chk(s ? "ser_first_b" : "ser_first_a", int'(sf), int'(e.f));
                chk(s ? "ser_last_b" : "ser_last_a", int'(sl), int'(e.l));
                pv[s] = 1;
                py[s] = e.y;
            end
        end
        if (dn) begin
            dcnt[s]++;
            if ((s ? rb.size() : ra.size()) == 0) chk(s ? "extra_done_b" : "extra_done_a", 1, 0);
            else begin
                if (s) r = rb.pop_front(); else r = ra.pop_front();
                chk(s ? "final_rem_b" : "final_rem_a", int'(fr), r);
            end
        end
    endtask
    always @(negedge clk)
        if (reset) begin pv[0] = 0; pv[1] = 0; end
        else begin mon(0); mon(1); end
    // expected bits come from the arithmetic prefix value, not a residue table
    task automatic push_frame(input bit s, input logic [7:0] d, input int rem);
        int w, p;
        exp_t e;
        w = s ? 7 : 8;
        p = 0;
        for (int i = w - 1; i >= 0; i--) begin
            p = 2 * p + int'(d[i]);
            e = '{b: d[i], f: (i == w - 1), l: (i == 0), y: (p % 5 == 0)};
            if (s) qb.push_back(e); else qa.push_back(e);
        end
        if (s) rb.push_back(rem); else ra.push_back(rem);
    endtask
    task automatic wait_ready(input bit s);
        int n = 0;
        while (!(s ? b.in_ready : a.in_ready) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk(s ? "ready_timeout_b" : "ready_timeout_a", 0, 1);
    endtask
    task automatic send(input bit s, input logic [7:0] d, input int rem);
        wait_ready(s);
        if (s) begin b.in_valid = 1; b.in_data = d[6:0]; end
        else begin a.in_valid = 1; a.in_data = d; end
        push_frame(s, d, rem);
        @(negedge clk);
        if (s) b.in_valid = 0; else a.in_valid = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
    initial begin
        int n, k, d0;
        a.in_valid = 1; a.in_data = 8'hFF;
        b.in_valid = 1; b.in_data = 7'h7F;
        repeat (3) @(negedge clk);
        chk("rst_in_ready_a", int'(a.in_ready), 1);
        chk("rst_ser_valid_a", int'(a.ser_valid), 0);
        chk("rst_done_a", int'(a.done), 0);
        chk("rst_exp_y_a", int'(a.exp_y), 0);
        chk("rst_final_rem_a", int'(a.final_rem), 0);
        chk("rst_in_ready_b", int'(b.in_ready), 1);
        chk("rst_ser_valid_b", int'(b.ser_valid), 0);
        a.in_valid = 0; b.in_valid = 0; reset = 0;
        @(negedge clk);
        chk("no_accept_ser_valid_a", int'(a.ser_valid), 0);
        chk("no_accept_cnt_a", acc[0], 0);
        chk("no_accept_cnt_b", acc[1], 0);
        send(0, 8'd200, 0);
        send(1, 8'b0111_0110, 3);
        send(1, 8'd100, 0);
        chk("period_b", t_acc[1] - t_prev[1], 9);
        send(0, 8'd5, 0);
        send(0, 8'd7, 2);
        chk("period_a", t_acc[0] - t_prev[0], 11);
        wait_ready(0);
        n = acc[0];
        a.in_valid = 1; a.in_data = 8'hA5;
        push_frame(0, 8'hA5, 0);
        @(negedge clk);
        a.in_data = 8'hFF;
        repeat (2) @(negedge clk);
        a.in_data = 8'd123;
        push_frame(0, 8'd123, 3);
        k = 0;
        while (acc[0] < n + 2 && k < 100) begin @(negedge clk); k++; end
        a.in_valid = 0;
        chk("t5_accepts", acc[0] - n, 2);
        wait_ready(0);
        a.in_valid = 1; a.in_data = 8'hB3;
        push_frame(0, 8'hB3, 4);
        @(negedge clk);
        a.in_valid = 0;
        repeat (3) @(negedge clk);
        d0 = dcnt[0];
        #1 reset = 1;
        #1;
        chk("abort_ser_valid", int'(a.ser_valid), 0);
        chk("abort_ser_out", int'(a.ser_out), 0);
        chk("abort_exp_y", int'(a.exp_y), 0);
        chk("abort_final_rem", int'(a.final_rem), 0);
        chk("abort_in_ready", int'(a.in_ready), 1);
        qa.delete();
        ra.delete();
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("abort_no_done", dcnt[0] - d0, 0);
        send(0, 8'd201, 1);
        k = 0;
        while (qa.size() + qb.size() + ra.size() + rb.size() != 0 && k < 200) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        chk("drain", qa.size() + qb.size() + ra.size() + rb.size(), 0);
        chk("frames_a", dcnt[0], 6);
        chk("frames_b", dcnt[1], 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
